// File: rtl/conv_win_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 window generator.
// master drives pixels and consumes windows; slave is the generator.
interface conv_win_gen_if #(
    parameter int DATA_W = 8
);
    logic                  sof;
    logic                  pix_vld;
    logic [DATA_W-1:0]     pix_in;
    logic                  win_vld;
    logic [9*DATA_W-1:0]   win_out;
    logic                  frame_done;

    modport master (
        output sof,
        output pix_vld,
        output pix_in,
        input  win_vld,
        input  win_out,
        input  frame_done
    );

    modport slave (
        input  sof,
        input  pix_vld,
        input  pix_in,
        output win_vld,
        output win_out,
        output frame_done
    );
endinterface

// File: rtl/conv_win_gen.sv
// Streaming 3x3 sliding-window generator over a raster pixel stream.
// Two row line buffers feed a 3x3 register window; one registered stage.
module conv_win_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_win_gen_if.slave  strm
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;
    logic          acc;
    logic          hit;
    logic          last;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_out;
    logic [DATA_W-1:0] lb1_out;

    logic [DATA_W-1:0] win [3][3];
    logic              vld_q;
    logic              done_q;

    assign acc     = strm.pix_vld;
    assign lb0_out = lb0[IMG_W-1];
    assign lb1_out = lb1[IMG_W-1];

    // Position of the incoming pixel (sof forces 0,0) and the next position.
    always_comb begin
        cur_col = strm.sof ? '0 : col;
        cur_row = strm.sof ? '0 : row;
        nxt_col = cur_col + CW'(1);
        nxt_row = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            if (cur_row == ROW_LAST) begin
                nxt_row = '0;
            end else begin
                nxt_row = cur_row + RW'(1);
            end
        end
        hit  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Two row-delay shift registers; contents never need clearing.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[0] <= strm.pix_in;
            lb1[0] <= lb0_out;
            for (int i = 1; i < IMG_W; i++) begin
                lb0[i] <= lb0[i-1];
                lb1[i] <= lb1[i-1];
            end
        end
    end

    // 3x3 window: shift left, load right column from the buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_out;
            win[1][2] <= lb0_out;
            win[2][2] <= strm.pix_in;
        end
    end

    // Window-valid and end-of-frame pulses, one per qualifying pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            vld_q  <= acc & hit;
            done_q <= acc & last;
        end
    end

    assign strm.win_vld    = vld_q;
    assign strm.frame_done = done_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign strm.win_out[DATA_W*(3*r+c) +: DATA_W] = win[r][c];
        end
    end
endmodule

// File: tb/tb_conv_win_gen.sv
// Scoreboard bench for conv_win_gen: a 4x4 and a 32x32 instance.
// Expected windows are queued at drive time and popped on win_vld.
module tb_conv_win_gen;
    typedef struct {
        int          due;
        logic [71:0] w;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_win_gen_if #(.DATA_W(8)) b4 ();
    conv_win_gen_if #(.DATA_W(8)) b32 ();

    conv_win_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (b4)
    );

    conv_win_gen #(.DATA_W(8), .IMG_W(32), .IMG_H(32)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .strm  (b32)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q [2][$];
    int nwin [2];
    int nfd [2];
    logic [71:0] fw [2];
    logic [7:0] fm [32][32];
    int mr = 0;
    int mc = 0;

    localparam logic [71:0] W_FIRST = 72'h0A_09_08_06_05_04_02_01_00;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int d);
        logic v, f;
        logic [71:0] w;
        exp_t e;
        v = d ? b32.win_vld : b4.win_vld;
        f = d ? b32.frame_done : b4.frame_done;
        w = d ? b32.win_out : b4.win_out;
        while (q[d].size() > 0 && q[d][0].due < cyc) begin
            e = q[d].pop_front();
            check($sformatf("late%0d", d), cyc, e.due);
        end
        if (v) begin
            if (nwin[d] == 0) fw[d] = w;
            nwin[d]++;
            if (f) nfd[d]++;
            if (q[d].size() == 0) begin
                check($sformatf("extra%0d", d), v, 0);
            end else begin
                e = q[d].pop_front();
                check($sformatf("due%0d", d), cyc, e.due);
                check($sformatf("win%0d", d), w, e.w);
                check($sformatf("fd%0d", d), f, e.fd);
            end
        end else if (f) begin
            check($sformatf("fd_alone%0d", d), f, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_vld4", b4.win_vld, 0);
            check("rst_fd4", b4.frame_done, 0);
            check("rst_win4", b4.win_out, 0);
            check("rst_vld32", b32.win_vld, 0);
            check("rst_win32", b32.win_out, 0);
        end else begin
            mon(0);
            mon(1);
        end
    end

    task automatic send(input int d, input bit s, input logic [7:0] p);
        int W = d ? 32 : 4;
        exp_t e;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        fm[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            e.due = cyc + 1;
            e.fd  = (mr == W-1) && (mc == W-1);
            e.w   = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[8*(3*r+c) +: 8] = fm[mr-2+r][mc-2+c];
            q[d].push_back(e);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == W-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        if (d == 0) begin
            b4.sof = s; b4.pix_vld = 1'b1; b4.pix_in = p;
        end else begin
            b32.sof = s; b32.pix_vld = 1'b1; b32.pix_in = p;
        end
        @(posedge clk);
        #2;
        b4.pix_vld = 1'b0; b4.sof = 1'b0;
        b32.pix_vld = 1'b0; b32.sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame4(input int off, input int gap, input bit s0);
        for (int i = 0; i < 16; i++) begin
            send(0, (i == 0) && s0, 8'(i + off));
            if (gap > 0) idle($urandom_range(gap, 0));
        end
    endtask

    task automatic clr();
        nwin[0] = 0; nwin[1] = 0;
        nfd[0] = 0; nfd[1] = 0;
    endtask

    initial begin
        b4.sof = 0; b4.pix_vld = 0; b4.pix_in = 0;
        b32.sof = 0; b32.pix_vld = 0; b32.pix_in = 0;
        clr();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // continuous frame
        clr();
        frame4(0, 0, 0);
        idle(3);
        check("t1_cnt", nwin[0], 4);
        check("t1_fd", nfd[0], 1);
        check("t1_first", fw[0], W_FIRST);

        // random gaps
        clr();
        frame4(0, 3, 1);
        idle(3);
        check("t2_cnt", nwin[0], 4);
        check("t2_fd", nfd[0], 1);
        check("t2_first", fw[0], W_FIRST);

        // two back-to-back frames, first one with distinct data
        clr();
        frame4(8'h40, 0, 1);
        frame4(0, 0, 1);
        idle(3);
        check("t3_cnt", nwin[0], 8);
        check("t3_fd", nfd[0], 2);

        // sof at old pixel 9
        clr();
        for (int i = 0; i < 9; i++) send(0, i == 0, 8'(8'h80 + i));
        frame4(0, 0, 1);
        idle(3);
        check("t4_cnt", nwin[0], 4);
        check("t4_first", fw[0], W_FIRST);

        // reset right after pixel 11
        for (int i = 0; i < 12; i++) send(0, i == 0, 8'(8'hC0 + i));
        rst_n = 1'b0;
        #1;
        check("t5_drop", b4.win_vld, 0);
        q[0].delete();
        mr = 0;
        mc = 0;
        idle(2);
        rst_n = 1'b1;
        clr();
        frame4(0, 0, 0);
        idle(3);
        check("t5_cnt", nwin[0], 4);
        check("t5_first", fw[0], W_FIRST);

        // 32x32 random frame
        clr();
        for (int i = 0; i < 1024; i++) begin
            send(1, i == 0, 8'($urandom_range(255, 0)));
            if ($urandom_range(7, 0) == 0) idle(1);
        end
        idle(3);
        check("t6_cnt", nwin[1], 900);
        check("t6_fd", nfd[1], 1);
        check("q4_empty", q[0].size(), 0);
        check("q32_empty", q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
